// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: word type, flag
// constants, default cache geometry and fetch FSM states.
package inst_fetcher_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned ICACHE_LINES_DEF = 64;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic  TRUE      = 1'b1;
    localparam logic  FALSE     = 1'b0;
    localparam word_t ZERO_WORD = '0;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetcher-side bundle: memory controller request/response, decoder issue
// and ROB redirect signals.
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    logic  out_mem_flag;
    word_t out_mem_addr;
    logic  in_mem_flag;
    word_t in_mem_data;
    logic  in_dec_stall;
    logic  out_inst_flag;
    word_t out_inst;
    word_t out_pc;
    logic  in_rob_xbp;
    word_t in_rob_pc;

    modport master (
        output out_mem_flag, out_mem_addr, out_inst_flag, out_inst, out_pc,
        input  in_mem_flag, in_mem_data, in_dec_stall, in_rob_xbp, in_rob_pc
    );

    modport slave (
        input  out_mem_flag, out_mem_addr, out_inst_flag, out_inst, out_pc,
        output in_mem_flag, in_mem_data, in_dec_stall, in_rob_xbp, in_rob_pc
    );

endinterface

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache with combinational
// lookup and a synchronous fill port; reset clears only the valid bits.
module inst_fetcher_icache_dm
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned LINES = ICACHE_LINES_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  word_t pc_i,
    output logic  hit_o,
    output word_t data_o,
    input  logic  fill_i,
    input  word_t fill_data_i
);

    localparam int unsigned IDX   = $clog2(LINES);
    localparam int unsigned TAG_W = DATA_W - IDX - 2;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    word_t            data_q [LINES];

    logic [IDX-1:0]   idx;
    logic [TAG_W-1:0] tag;

    assign idx = pc_i[IDX+1:2];
    assign tag = pc_i[DATA_W-1:IDX+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[idx] <= TRUE;
        end
    end

    // Tag/data need no reset: every read is qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= fill_data_i;
        end
    end

    assign hit_o  = valid_q[idx] && (tag_q[idx] == tag);
    assign data_o = data_q[idx];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: PC, icache lookup, single-outstanding miss
// handling toward the memory controller, and ROB mispredict redirect.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned ICACHE_LINES = ICACHE_LINES_DEF,
    parameter word_t       RESET_PC     = 32'h0
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    inst_fetcher_if.master bus
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    logic         mem_flag_q, mem_flag_d;
    word_t        mem_addr_q, mem_addr_d;
    logic         inst_flag_q, inst_flag_d;
    word_t        inst_q, inst_d;
    word_t        out_pc_q, out_pc_d;

    logic  hit;
    word_t cache_data;
    logic  fill_en;
    logic  issue_free;

    inst_fetcher_icache_dm #(.LINES(ICACHE_LINES)) u_icache (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_q),
        .hit_o       (hit),
        .data_o      (cache_data),
        .fill_i      (fill_en && rdy),
        .fill_data_i (bus.in_mem_data)
    );

    assign issue_free = !inst_flag_q || !bus.in_dec_stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_flag_d  = FALSE;
        mem_addr_d  = mem_addr_q;
        inst_flag_d = inst_flag_q;
        inst_d      = inst_q;
        out_pc_d    = out_pc_q;
        fill_en     = FALSE;

        if (bus.in_rob_xbp) begin
            pc_d        = bus.in_rob_pc;
            state_d     = RUN;
            inst_flag_d = FALSE;
        end else begin
            if (issue_free) inst_flag_d = FALSE;
            unique case (state_q)
                RUN: begin
                    if (issue_free) begin
                        if (hit) begin
                            inst_flag_d = TRUE;
                            inst_d      = cache_data;
                            out_pc_d    = pc_q;
                            pc_d        = pc_q + 32'd4;
                        end else begin
                            mem_flag_d  = TRUE;
                            mem_addr_d  = pc_q;
                            state_d     = WAIT_MEM;
                        end
                    end
                end
                // Issue register is always empty here, so the response issues directly.
                WAIT_MEM: begin
                    if (bus.in_mem_flag) begin
                        fill_en     = TRUE;
                        inst_flag_d = TRUE;
                        inst_d      = bus.in_mem_data;
                        out_pc_d    = pc_q;
                        pc_d        = pc_q + 32'd4;
                        state_d     = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            mem_flag_q  <= FALSE;
            mem_addr_q  <= ZERO_WORD;
            inst_flag_q <= FALSE;
            inst_q      <= ZERO_WORD;
            out_pc_q    <= ZERO_WORD;
        end else if (rdy) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_flag_q  <= mem_flag_d;
            mem_addr_q  <= mem_addr_d;
            inst_flag_q <= inst_flag_d;
            inst_q      <= inst_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign bus.out_mem_flag  = mem_flag_q;
    assign bus.out_mem_addr  = mem_addr_q;
    assign bus.out_inst_flag = inst_flag_q;
    assign bus.out_inst      = inst_q;
    assign bus.out_pc        = out_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher: the bench acts as memory controller,
// decoder and ROB, and predicts every output from a line-address cache model.
module tb_inst_fetcher;
    import inst_fetcher_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;

    inst_fetcher_if bus();

    inst_fetcher #(.ICACHE_LINES(64), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: which word address each of the 64 lines currently holds.
    logic [31:0] line_of [int unsigned];
    logic [31:0] m_pc;
    bit          m_wait;
    int unsigned m_cnt;
    int unsigned mem_lat = 5;
    bit          e_flag, e_mf;
    logic [31:0] e_inst, e_pc, e_addr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int unsigned idx;
        idx = (a >> 2) & 32'd63;
        return line_of.exists(idx) && (line_of[idx] == a);
    endfunction

    task automatic compare_outputs(input string pfx);
        check({pfx, "inst_flag"}, {31'b0, bus.out_inst_flag}, {31'b0, e_flag});
        check({pfx, "mem_flag"},  {31'b0, bus.out_mem_flag},  {31'b0, e_mf});
        check({pfx, "mem_addr"},  bus.out_mem_addr, e_addr);
        check({pfx, "inst"},      bus.out_inst, e_inst);
        check({pfx, "pc"},        bus.out_pc, e_pc);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_wait = 0; m_cnt = 0;
        e_flag = 0; e_mf = 0; e_inst = '0; e_pc = '0; e_addr = '0;
        line_of.delete();
    endtask

    // Called at a negedge: drive reset with the design frozen, check, release.
    task automatic do_reset();
        rdy = 0; bus.in_mem_flag = 0; bus.in_mem_data = '0;
        bus.in_dec_stall = 0; bus.in_rob_xbp = 0; bus.in_rob_pc = '0;
        rst = 0;
        #1;
        model_reset();
        compare_outputs("reset_");
        #1 rst = 1;
        @(negedge clk);
    endtask

    // One clock: check outputs, drive inputs, advance the model, wait a cycle.
    task automatic step(input bit r, input bit st, input bit x, input logic [31:0] rp, input bit stray_ok);
        bit resp, stray, free;
        compare_outputs("");
        resp  = m_wait && (m_cnt == 0) && r;
        stray = stray_ok && !m_wait && ($urandom_range(0, 31) == 0);
        rdy = r;
        bus.in_dec_stall = st;
        bus.in_rob_xbp   = x;
        bus.in_rob_pc    = rp;
        bus.in_mem_flag  = resp || stray;
        bus.in_mem_data  = resp ? memfn(e_addr) : 32'($urandom);
        if (r) begin
            if (x) begin
                m_pc = rp; m_wait = 0; e_flag = 0; e_mf = 0;
            end else begin
                free = !e_flag || !st;
                e_mf = 0;
                if (free) e_flag = 0;
                if (m_wait) begin
                    if (m_cnt > 0) m_cnt--;
                    else begin
                        line_of[(m_pc >> 2) & 32'd63] = m_pc;
                        e_flag = 1; e_inst = memfn(m_pc); e_pc = m_pc;
                        m_pc = m_pc + 32'd4; m_wait = 0;
                    end
                end else if (free) begin
                    if (m_hit(m_pc)) begin
                        e_flag = 1; e_inst = memfn(m_pc); e_pc = m_pc;
                        m_pc = m_pc + 32'd4;
                    end else begin
                        e_mf = 1; e_addr = m_pc; m_wait = 1; m_cnt = mem_lat;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1, 0, 0, '0, 0);
    endtask

    initial begin
        bit ok;
        bus.in_mem_flag = 0; bus.in_mem_data = '0; bus.in_dec_stall = 0;
        bus.in_rob_xbp = 0; bus.in_rob_pc = '0;
        @(negedge clk);
        do_reset();

        // Cold start from 0 with 5-cycle memory, filling the first few lines.
        mem_lat = 5;
        idle(45);

        // Re-fetch of the filled loop body: hits only.
        step(1, 0, 1, 32'h0, 0);
        idle(5);

        // Decoder stall holding an issued hit.
        step(1, 0, 1, 32'h0, 0);
        step(1, 0, 0, '0, 0);
        for (int unsigned i = 0; i < 3; i++) step(1, 1, 0, '0, 0);
        idle(3);

        // Flush coincident with the memory response: fill must be dropped.
        step(1, 0, 1, 32'h200, 0);
        ok = 0;
        for (int unsigned i = 0; i < 50; i++) begin
            if (m_wait && m_cnt == 0) begin ok = 1; break; end
            step(1, 0, 0, '0, 0);
        end
        check("t4_wait_resp", {31'b0, ok}, 32'd1);
        step(1, 0, 1, 32'h100, 0);
        idle(10);
        step(1, 0, 1, 32'h200, 0);
        idle(10);

        // Aliasing lines 0x000 / 0x100 / 0x000.
        step(1, 0, 1, 32'h0, 0);
        idle(6);
        step(1, 0, 1, 32'h100, 0);
        idle(10);
        step(1, 0, 1, 32'h0, 0);
        idle(10);

        // rdy low mid-miss; response only after rdy returns.
        mem_lat = 3;
        step(1, 0, 1, 32'h300, 0);
        ok = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            if (m_wait) begin ok = 1; break; end
            step(1, 0, 0, '0, 0);
        end
        check("t6_wait_req", {31'b0, ok}, 32'd1);
        for (int unsigned i = 0; i < 4; i++) step(0, 0, 0, '0, 0);
        idle(10);

        // Randomized traffic, with one reset in the middle.
        for (int unsigned i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            if (i == 1500) do_reset();
            mem_lat = $urandom_range(1, 6);
            rp = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 24) == 0, rp, 1);
        end
        compare_outputs("final_");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
